// File: rtl/oc8051_cxrom_arbiter.sv
// Code-ROM port arbiter: CPU instruction fetches share one ROM port with a
// burst-reading DMA engine; DMA is forced through after MAX_WAIT lost cycles.
module oc8051_cxrom_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  input  logic [15:0] cpu_req_addr,
  output logic        cpu_req_ready,
  output logic        cpu_rsp_valid,
  output logic [31:0] cpu_rsp_data,
  input  logic        dma_start,
  input  logic [15:0] dma_base,
  input  logic [7:0]  dma_len,
  output logic        dma_busy,
  output logic        dma_rsp_valid,
  output logic [15:0] dma_rsp_addr,
  output logic [31:0] dma_rsp_data,
  output logic        dma_done,
  output logic [15:0] rom_addr,
  input  logic [31:0] rom_data
);

  localparam logic [7:0] MAX_WAIT_W = 8'(MAX_WAIT);

  typedef enum logic {IDLE, BURST} state_t;

  state_t      state, state_nxt;
  logic [15:0] dma_addr;
  logic [7:0]  dma_cnt;
  logic [7:0]  wait_cnt;
  logic        cpu_grant;
  logic        dma_grant;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grants come only from requests and state, never from response registers.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_nxt = state;
    cpu_grant = 1'b0;
    dma_grant = 1'b0;
    rom_addr  = 16'h0000;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          cpu_grant = cpu_req_valid;
          if (dma_start && dma_len != 8'd0) state_nxt = BURST;
        end
        BURST: begin
          cpu_grant = cpu_req_valid && (wait_cnt < MAX_WAIT_W);
          dma_grant = !cpu_grant;
          if (dma_grant && dma_cnt == 8'd1) state_nxt = IDLE;
        end
      endcase
      if (cpu_grant)      rom_addr = cpu_req_addr;
      else if (dma_grant) rom_addr = dma_addr;
    end
  end

  assign cpu_req_ready = cpu_grant;
  assign dma_busy      = (state == BURST);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      dma_addr      <= 16'h0000;
      dma_cnt       <= 8'd0;
      wait_cnt      <= 8'd0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_data  <= 32'h0;
      dma_rsp_valid <= 1'b0;
      dma_rsp_addr  <= 16'h0000;
      dma_rsp_data  <= 32'h0;
      dma_done      <= 1'b0;
    end else begin
      cpu_rsp_valid <= cpu_grant;
      dma_rsp_valid <= dma_grant;
      dma_done      <= dma_grant && (dma_cnt == 8'd1);
      if (cpu_grant) cpu_rsp_data <= rom_data;

      if (state == IDLE) begin
        if (dma_start && dma_len != 8'd0) begin
          dma_addr <= dma_base;
          dma_cnt  <= dma_len;
          wait_cnt <= 8'd0;
        end
      end else if (dma_grant) begin
        dma_rsp_addr <= dma_addr;
        dma_rsp_data <= rom_data;
        dma_addr     <= dma_addr + 16'd4;
        dma_cnt      <= dma_cnt - 8'd1;
        wait_cnt     <= 8'd0;
      end else if (cpu_grant) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_oc8051_cxrom_arbiter.sv
// Directed bench for the code-ROM arbiter: a per-cycle vector table plus
// hand-written starvation and mid-burst reset sequences.
module tb_oc8051_cxrom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid;
  logic [15:0] cpu_req_addr;
  logic        cpu_req_ready;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_data;
  logic        dma_start;
  logic [15:0] dma_base;
  logic [7:0]  dma_len;
  logic        dma_busy;
  logic        dma_rsp_valid;
  logic [15:0] dma_rsp_addr;
  logic [31:0] dma_rsp_data;
  logic        dma_done;
  logic [15:0] rom_addr;
  logic [31:0] rom_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [15:0] a);
    return {~a, a ^ 16'h5A3C};
  endfunction

  assign rom_data = rom_fn(rom_addr);

  oc8051_cxrom_arbiter #(.MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr),
    .cpu_req_ready(cpu_req_ready), .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rsp_data(cpu_rsp_data),
    .dma_start(dma_start), .dma_base(dma_base), .dma_len(dma_len),
    .dma_busy(dma_busy), .dma_rsp_valid(dma_rsp_valid),
    .dma_rsp_addr(dma_rsp_addr), .dma_rsp_data(dma_rsp_data),
    .dma_done(dma_done), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        cv;
    logic [15:0] ca;
    logic        ds;
    logic [15:0] db;
    logic [7:0]  dl;
    logic        rdy;
    logic [15:0] ra;
    logic        crv;
    logic [15:0] cra;
    logic        drv;
    logic [15:0] dra;
    logic        dd;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic drive(input logic r, input logic cv, input logic [15:0] ca,
                       input logic ds, input logic [15:0] db, input logic [7:0] dl);
    @(negedge clk);
    rst = r; cpu_req_valid = cv; cpu_req_addr = ca;
    dma_start = ds; dma_base = db; dma_len = dl;
    #1;
  endtask

  initial begin
    bit seen;
    //                 rst cv ca       ds db       dl    rdy ra       crv cra      drv dra      dd busy
    vecs.push_back(vec_t'{1, 1, 16'h0010, 0, 16'h0000, 8'd0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0});
    vecs.push_back(vec_t'{0, 1, 16'h0010, 0, 16'h0000, 8'd0, 1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 0});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'h0000, 1, 16'h0010, 0, 16'h0000, 0, 0});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0});
    // plain burst of three words
    vecs.push_back(vec_t'{0, 0, 16'h0000, 1, 16'h0100, 8'd3, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'h0100, 0, 16'h0000, 0, 16'h0000, 0, 1});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'h0104, 0, 16'h0000, 1, 16'h0100, 0, 1});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'h0108, 0, 16'h0000, 1, 16'h0104, 0, 1});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0108, 1, 0});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0108, 0, 0});
    // address wrap at the top of the 64 KiB space
    vecs.push_back(vec_t'{0, 0, 16'h0000, 1, 16'hFFF8, 8'd3, 0, 16'h0000, 0, 16'h0000, 0, 16'h0108, 0, 0});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'hFFF8, 0, 16'h0000, 0, 16'h0108, 0, 1});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'hFFFC, 0, 16'h0000, 1, 16'hFFF8, 0, 1});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFC, 0, 1});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 0});
    // zero-length start is ignored
    vecs.push_back(vec_t'{0, 0, 16'h0000, 1, 16'h2000, 8'd0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0});
    // start during a burst is ignored
    vecs.push_back(vec_t'{0, 0, 16'h0000, 1, 16'h0200, 8'd2, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 1, 16'h3000, 8'd5, 0, 16'h0200, 0, 16'h0000, 0, 16'h0000, 0, 1});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'h0204, 0, 16'h0000, 1, 16'h0200, 0, 1});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0204, 1, 0});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0204, 0, 0});
    // CPU wins inside a burst while under the wait limit
    vecs.push_back(vec_t'{0, 1, 16'h0020, 1, 16'h0400, 8'd1, 1, 16'h0020, 0, 16'h0000, 0, 16'h0204, 0, 0});
    vecs.push_back(vec_t'{0, 1, 16'h0024, 0, 16'h0000, 8'd0, 1, 16'h0024, 1, 16'h0020, 0, 16'h0204, 0, 1});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'h0400, 1, 16'h0024, 0, 16'h0204, 0, 1});
    vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 16'h0000, 8'd0, 0, 16'h0000, 0, 16'h0024, 1, 16'h0400, 1, 0});

    rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_addr = '0;
    dma_start = 1'b0; dma_base = '0; dma_len = '0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].cv, vecs[i].ca, vecs[i].ds, vecs[i].db, vecs[i].dl);
      check($sformatf("v%0d cpu_req_ready", i), 32'(cpu_req_ready), 32'(vecs[i].rdy));
      check($sformatf("v%0d rom_addr", i),      32'(rom_addr),      32'(vecs[i].ra));
      check($sformatf("v%0d cpu_rsp_valid", i), 32'(cpu_rsp_valid), 32'(vecs[i].crv));
      check($sformatf("v%0d dma_rsp_valid", i), 32'(dma_rsp_valid), 32'(vecs[i].drv));
      check($sformatf("v%0d dma_rsp_addr", i),  32'(dma_rsp_addr),  32'(vecs[i].dra));
      check($sformatf("v%0d dma_done", i),      32'(dma_done),      32'(vecs[i].dd));
      check($sformatf("v%0d dma_busy", i),      32'(dma_busy),      32'(vecs[i].busy));
      if (vecs[i].crv) check($sformatf("v%0d cpu_rsp_data", i), cpu_rsp_data, rom_fn(vecs[i].cra));
      if (vecs[i].drv) check($sformatf("v%0d dma_rsp_data", i), dma_rsp_data, rom_fn(vecs[i].dra));
    end

    // Starvation: continuous CPU traffic, burst of two with MAX_WAIT=8.
    drive(0, 0, 16'h0000, 1, 16'h0800, 8'd2);
    for (int k = 0; k <= 18; k++) begin
      logic        exp_dma;
      logic [15:0] ca;
      ca = 16'h1000 + 16'(4 * k);
      exp_dma = (k == 8) || (k == 17);
      drive(0, 1, ca, 0, 16'h0000, 8'd0);
      check($sformatf("starve k%0d ready", k), 32'(cpu_req_ready), 32'(!exp_dma));
      check($sformatf("starve k%0d rom_addr", k), 32'(rom_addr),
            32'(exp_dma ? ((k == 8) ? 16'h0800 : 16'h0804) : ca));
      check($sformatf("starve k%0d busy", k), 32'(dma_busy), 32'(k < 18));
      check($sformatf("starve k%0d dma_rsp_valid", k), 32'(dma_rsp_valid), 32'((k == 9) || (k == 18)));
      check($sformatf("starve k%0d done", k), 32'(dma_done), 32'(k == 18));
    end
    check("starve last addr", 32'(dma_rsp_addr), 32'(16'h0804));

    // Reset after two of five words have been granted.
    drive(0, 0, 16'h0000, 1, 16'h0500, 8'd5);
    drive(0, 0, 16'h0000, 0, 16'h0000, 8'd0);
    check("rstmid g0 rom_addr", 32'(rom_addr), 32'(16'h0500));
    drive(0, 0, 16'h0000, 0, 16'h0000, 8'd0);
    check("rstmid g1 rom_addr", 32'(rom_addr), 32'(16'h0504));
    drive(1, 1, 16'h0030, 0, 16'h0000, 8'd0);
    check("rstmid rst ready", 32'(cpu_req_ready), 32'd0);
    check("rstmid rst rom_addr", 32'(rom_addr), 32'd0);
    drive(0, 0, 16'h0000, 0, 16'h0000, 8'd0);
    check("rstmid busy", 32'(dma_busy), 32'd0);
    check("rstmid dma_rsp_valid", 32'(dma_rsp_valid), 32'd0);
    check("rstmid dma_rsp_addr", 32'(dma_rsp_addr), 32'd0);
    check("rstmid dma_rsp_data", dma_rsp_data, 32'd0);
    check("rstmid cpu_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
    check("rstmid cpu_rsp_data", cpu_rsp_data, 32'd0);
    check("rstmid done", 32'(dma_done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 16'h0000, 0, 16'h0000, 8'd0);
      check($sformatf("rstmid quiet%0d rsp", k), 32'(dma_rsp_valid), 32'd0);
      check($sformatf("rstmid quiet%0d done", k), 32'(dma_done), 32'd0);
    end

    // A fresh burst runs normally after the abort.
    drive(0, 0, 16'h0000, 1, 16'h0600, 8'd1);
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      drive(0, 0, 16'h0000, 0, 16'h0000, 8'd0);
      if (dma_done) begin
        seen = 1'b1;
        check("restart addr", 32'(dma_rsp_addr), 32'(16'h0600));
        check("restart data", dma_rsp_data, rom_fn(16'h0600));
        check("restart busy", 32'(dma_busy), 32'd0);
      end
    end
    check("restart done seen", 32'(seen), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
